// File: rtl/fifo_pkg.sv
// Shared defaults for the single-clock FIFO and its storage array.
package fifo_pkg;

  localparam int unsigned DefaultDataWidth = 32;
  localparam int unsigned DefaultAddrWidth = 4;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register array: synchronous write, registered read with enable.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter int unsigned ADDR_WIDTH = DefaultAddrWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/async_fifo.sv
// Single-clock FIFO: wrap-bit pointers, full/empty decode and handshake qualification.
module async_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter int unsigned ADDR_WIDTH = DefaultAddrWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic                wr_accept;
  logic                rd_accept;

  // Flags come from registered pointers only, never from the request inputs.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                 (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);

  assign wr_accept = wr_en && !full;
  assign rd_accept = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wr_data (din),
    .rd_en   (rd_accept),
    .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rd_data (dout)
  );

endmodule

// File: tb/tb_async_fifo.sv
// Directed bench for async_fifo: reset, fill/drain, streaming, boundary and mid-stream reset.
module tb_async_fifo;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned Depth = 16;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] din;
  logic          rd_en;
  logic [DW-1:0] dout;
  logic          full;
  logic          empty;

  int n_checks = 0;
  int n_pass   = 0;

  async_fifo #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .wr_en (wr_en),
    .din   (din),
    .rd_en (rd_en),
    .dout  (dout),
    .full  (full),
    .empty (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Advance one rising edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;
  endtask

  task automatic push(input logic [DW-1:0] d);
    wr_en = 1'b1;
    rd_en = 1'b0;
    din   = d;
    tick();
    idle();
  endtask

  task automatic pop_check(input string tag, input logic [DW-1:0] exp);
    wr_en = 1'b0;
    rd_en = 1'b1;
    tick();
    idle();
    check(tag, 64'(dout), 64'(exp));
  endtask

  initial begin
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_word;
    int            m_count;
    int            n_wr;
    int            n_rd;
    int            cyc;
    logic          do_wr;
    logic          do_rd;

    idle();
    rst = 1'b1;
    repeat (5) tick();
    rst = 1'b0;
    check("reset_empty", 64'(empty), 64'd1);
    check("reset_full", 64'(full), 64'd0);
    check("reset_dout", 64'(dout), 64'd0);

    // Read while empty: nothing moves
    rd_en = 1'b1;
    tick();
    idle();
    check("rd_empty_empty", 64'(empty), 64'd1);
    check("rd_empty_dout", 64'(dout), 64'd0);

    // Fill
    for (int i = 0; i < Depth; i++) begin
      push(32'h1A2B_0000 + DW'(i));
      check("fill_empty", 64'(empty), 64'd0);
      check("fill_full", 64'(full), (i == Depth - 1) ? 64'd1 : 64'd0);
    end
    push(32'h1A2B_0010);
    check("over_write_full", 64'(full), 64'd1);

    // Drain
    for (int i = 0; i < Depth; i++) begin
      pop_check("drain_data", 32'h1A2B_0000 + DW'(i));
      check("drain_full", 64'(full), 64'd0);
      check("drain_empty", 64'(empty), (i == Depth - 1) ? 64'd1 : 64'd0);
    end
    pop_check("under_read_hold", 32'h1A2B_000F);
    check("under_read_empty", 64'(empty), 64'd1);

    // Streaming: full rate reads for the first 32 words, then ~70% duty
    m_count = 0;
    n_wr    = 0;
    n_rd    = 0;
    cyc     = 0;
    while (n_rd < 64 && cyc < 1000) begin
      do_wr = (n_wr < 64) && (m_count < Depth);
      do_rd = (m_count > 0) && ((n_rd < 32) || ((cyc % 10) < 7));
      wr_en = do_wr;
      rd_en = do_rd;
      din   = 32'h1A2B_0000 + DW'(n_wr);
      tick();
      if (do_rd) begin
        exp_word = q.pop_front();
        check("stream_data", 64'(dout), 64'(exp_word));
        n_rd++;
        m_count--;
      end
      if (do_wr) begin
        q.push_back(32'h1A2B_0000 + DW'(n_wr));
        n_wr++;
        m_count++;
      end
      check("stream_empty", 64'(empty), (m_count == 0) ? 64'd1 : 64'd0);
      check("stream_full", 64'(full), (m_count == Depth) ? 64'd1 : 64'd0);
      cyc++;
    end
    idle();
    check("stream_done", 64'(n_rd), 64'd64);

    // Simultaneous while full: read wins, write rejected
    for (int i = 0; i < Depth; i++) push(32'hC0DE_0000 + DW'(i));
    check("sim_full_pre", 64'(full), 64'd1);
    wr_en = 1'b1;
    rd_en = 1'b1;
    din   = 32'hDEAD_BEEF;
    tick();
    idle();
    check("sim_full_dout", 64'(dout), 64'hC0DE_0000);
    check("sim_full_flag", 64'(full), 64'd0);
    for (int i = 1; i < Depth; i++) pop_check("sim_full_rest", 32'hC0DE_0000 + DW'(i));
    check("sim_full_count15", 64'(empty), 64'd1);

    // Simultaneous while empty: write wins, dout holds
    wr_en = 1'b1;
    rd_en = 1'b1;
    din   = 32'h5A5A_0001;
    tick();
    idle();
    check("sim_empty_dout", 64'(dout), 64'hC0DE_000F);
    check("sim_empty_flag", 64'(empty), 64'd0);
    pop_check("sim_empty_read", 32'h5A5A_0001);
    check("sim_empty_after", 64'(empty), 64'd1);

    // Reset mid-stream with 7 words stored; reset overrides a concurrent write
    for (int i = 0; i < 7; i++) push(32'h7700_0000 + DW'(i));
    rst   = 1'b1;
    wr_en = 1'b1;
    din   = 32'hBAD0_0000;
    tick();
    rst = 1'b0;
    idle();
    check("midrst_empty", 64'(empty), 64'd1);
    check("midrst_full", 64'(full), 64'd0);
    check("midrst_dout", 64'(dout), 64'd0);
    for (int i = 0; i < 3; i++) push(32'h3300_0000 + DW'(i));
    for (int i = 0; i < 3; i++) pop_check("midrst_data", 32'h3300_0000 + DW'(i));
    check("midrst_final_empty", 64'(empty), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
